// File: rtl/jt51_kon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt51_kon_pkg
//  Purpose  : Shared definitions for the key-on scheduler: operator numbering,
//             slot geometry, and the mapping from key-on register mask bits
//             to operator order.
//  Revision : 1.0  initial release
// ============================================================================
package jt51_kon_pkg;

    // Operator numbering as used in the slot index {op[1:0], ch[2:0]}
    localparam logic [1:0] c_OP_M1 = 2'd0;
    localparam logic [1:0] c_OP_M2 = 2'd1;
    localparam logic [1:0] c_OP_C1 = 2'd2;
    localparam logic [1:0] c_OP_C2 = 2'd3;

    localparam int c_NUM_CH   = 8;
    localparam int c_NUM_OP   = 4;
    localparam int c_NUM_SLOT = 32;

    // The register mask is ordered M1,C1,M2,C2 (bits 0..3) while slots are
    // ordered M1,M2,C1,C2. Returns a mask indexed by operator number.
    function automatic logic [3:0] f_din_to_opmask(input logic [3:0] din);
        logic [3:0] m;
        m[c_OP_M1] = din[0];
        m[c_OP_C1] = din[1];
        m[c_OP_M2] = din[2];
        m[c_OP_C2] = din[3];
        return m;
    endfunction

    // Slot index of a given operator of a given channel
    function automatic logic [4:0] f_slot(input logic [1:0] op, input logic [2:0] ch);
        return {op, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_kon_pend.sv
`default_nettype none
// ============================================================================
//  Module   : jt51_kon_pend
//  Purpose  : Pending key-on buffer. One entry per channel holding a valid
//             flag and an operator-ordered mask. CPU writes are captured on
//             every clk edge; the commit strobe clears all valid flags, but a
//             write on that same edge survives and waits for the next frame.
//  Ports    : clk, rst          clock and synchronous active-high reset
//             i_we/i_ch/i_din   key-on register write (raw register mask)
//             i_commit          frame-boundary commit strobe
//             o_valid[7:0]      per-channel pending flag
//             o_mask[7:0][3:0]  per-channel pending mask, indexed by op
//  Revision : 1.0  initial release
// ============================================================================
module jt51_kon_pend
    import jt51_kon_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [2:0]      i_ch,
    input  logic [3:0]      i_din,
    input  logic            i_commit,
    output logic [7:0]      o_valid,
    output logic [7:0][3:0] o_mask
);

    logic [7:0]      r_valid;
    logic [7:0][3:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_mask  <= '0;
        end else begin
            if (i_commit) begin
                r_valid <= '0;
            end
            // Later assignment wins: a write on the commit edge is kept
            if (i_we) begin
                r_valid[i_ch] <= 1'b1;
                r_mask[i_ch]  <= f_din_to_opmask(i_din);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mask  = r_mask;

endmodule
`default_nettype wire

// File: rtl/jt51_kon.sv
`default_nettype none
// ============================================================================
//  Module   : jt51_kon
//  Purpose  : Key-on scheduler. Collects CPU key-on writes and CSM triggers,
//             commits them atomically at the frame boundary and streams one
//             keyon bit per clk_en tick aligned with the 32-slot pipeline.
//  Ports    : clk, rst          clock and synchronous active-high reset
//             i_clk_en          pipeline advance enable
//             i_zero            frame marker (slot 0 loads when set with clk_en)
//             i_kon_we          key-on write strobe (sampled every clk)
//             i_kon_ch          channel 0..7
//             i_kon_din         operator mask M1,C1,M2,C2 in bits 0..3
//             i_csm_en          CSM mode enable
//             i_timer_a_ovf     timer A overflow pulse
//             o_keyon           key state of the current slot
//             o_kon_state       committed per-slot key state
//             o_csm_active      high during a CSM-forced frame
//  Params   : OFFSET            slot rotation applied to the output lookup
//  Revision : 1.0  initial release
// ============================================================================
module jt51_kon
    import jt51_kon_pkg::*;
#(
    parameter int OFFSET = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clk_en,
    input  logic        i_zero,
    input  logic        i_kon_we,
    input  logic [2:0]  i_kon_ch,
    input  logic [3:0]  i_kon_din,
    input  logic        i_csm_en,
    input  logic        i_timer_a_ovf,
    output logic        o_keyon,
    output logic [31:0] o_kon_state,
    output logic        o_csm_active
);

    localparam logic [4:0] c_OFFSET = 5'(OFFSET % c_NUM_SLOT);

    logic [31:0]     r_state;
    logic [4:0]      r_idx;
    logic            r_keyon;
    logic            r_csm_pending;
    logic            r_csm_frame;

    logic            w_commit;
    logic [7:0]      w_valid;
    logic [7:0][3:0] w_mask;
    logic [31:0]     w_state_next;
    logic [4:0]      w_slot;

    assign w_commit = i_clk_en & i_zero;

    jt51_kon_pend u_pend (
        .clk      (clk),
        .rst      (rst),
        .i_we     (i_kon_we),
        .i_ch     (i_kon_ch),
        .i_din    (i_kon_din),
        .i_commit (w_commit),
        .o_valid  (w_valid),
        .o_mask   (w_mask)
    );

    // State as it will be after committing every valid pending entry
    always_comb begin
        w_state_next = r_state;
        for (int ch = 0; ch < c_NUM_CH; ch++) begin
            if (w_valid[ch]) begin
                for (int op = 0; op < c_NUM_OP; op++) begin
                    w_state_next[f_slot(2'(op), 3'(ch))] = w_mask[ch][op];
                end
            end
        end
    end

    // On the frame marker the lookup restarts at slot 0 regardless of r_idx,
    // which also resynchronises an early marker.
    assign w_slot = (i_zero ? 5'd0 : r_idx) + c_OFFSET;

    // Slot counter, committed state and output bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_idx   <= '0;
            r_keyon <= 1'b0;
        end else if (w_commit) begin
            r_state <= w_state_next;
            r_idx   <= 5'd1;
            // Slot 0 sees the post-commit state and the new CSM frame flag
            r_keyon <= r_csm_pending | w_state_next[w_slot];
        end else if (i_clk_en) begin
            r_idx   <= r_idx + 5'd1;
            r_keyon <= r_csm_frame | r_state[w_slot];
        end
    end

    // CSM trigger queue: one pending request becomes one forced frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csm_pending <= 1'b0;
            r_csm_frame   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_csm_frame   <= r_csm_pending;
                r_csm_pending <= 1'b0;
            end
            // An overflow on the commit edge itself queues the next frame
            if (i_timer_a_ovf && i_csm_en) begin
                r_csm_pending <= 1'b1;
            end
        end
    end

    assign o_keyon      = r_keyon;
    assign o_kon_state  = r_state;
    assign o_csm_active = r_csm_frame;

endmodule
`default_nettype wire

// File: tb/tb_jt51_kon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt51_kon
//  Purpose  : Directed self-checking bench for jt51_kon. Frames of clk_en
//             ticks are driven from a per-tick schedule; the keyon stream of
//             each frame is collected into a 32-bit word (bit n = slot n) and
//             compared against hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt51_kon;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clk_en;
    logic        i_zero;
    logic        i_kon_we;
    logic [2:0]  i_kon_ch;
    logic [3:0]  i_kon_din;
    logic        i_csm_en;
    logic        i_timer_a_ovf;
    logic        o_keyon;
    logic [31:0] o_kon_state;
    logic        o_csm_active;

    int n_vec = 0;
    int n_err = 0;

    // Per-tick schedule for the next frame
    logic       s_we  [32];
    logic [2:0] s_ch  [32];
    logic [3:0] s_din [32];
    logic       s_ovf [32];
    logic       s_csm [32];
    int         gap_at  = -1;
    logic       gap_exp = 1'b0;

    logic [31:0] ko;
    logic        cm;

    jt51_kon #(.OFFSET(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_clk_en      (i_clk_en),
        .i_zero        (i_zero),
        .i_kon_we      (i_kon_we),
        .i_kon_ch      (i_kon_ch),
        .i_kon_din     (i_kon_din),
        .i_csm_en      (i_csm_en),
        .i_timer_a_ovf (i_timer_a_ovf),
        .o_keyon       (o_keyon),
        .o_kon_state   (o_kon_state),
        .o_csm_active  (o_csm_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 32; k++) begin
            s_we[k]  = 1'b0;
            s_ch[k]  = 3'd0;
            s_din[k] = 4'd0;
            s_ovf[k] = 1'b0;
            s_csm[k] = 1'b0;
        end
        gap_at = -1;
    endtask

    task automatic sched_wr(input int t, input logic [2:0] ch, input logic [3:0] din);
        s_we[t]  = 1'b1;
        s_ch[t]  = ch;
        s_din[t] = din;
    endtask

    task automatic sched_ovf(input int t, input logic en);
        s_ovf[t] = 1'b1;
        s_csm[t] = en;
    endtask

    task automatic idle_inputs();
        i_kon_we      = 1'b0;
        i_kon_ch      = 3'd0;
        i_kon_din     = 4'd0;
        i_timer_a_ovf = 1'b0;
        i_csm_en      = 1'b0;
        i_zero        = 1'b0;
        i_clk_en      = 1'b1;
    endtask

    // One frame: zero on tick 0, then len-1 plain ticks. Bit k of ko is the
    // keyon sampled after tick k; cm is csm_active after tick 5.
    task automatic run_frame(input int len, output logic [31:0] f_ko, output logic f_cm);
        f_ko = '0;
        f_cm = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == gap_at) begin
                // Stalled pipeline: zero and a write arrive without clk_en
                for (int g = 0; g < 5; g++) begin
                    idle_inputs();
                    i_clk_en  = 1'b0;
                    i_zero    = 1'b1;
                    i_kon_we  = (g == 2);
                    i_kon_ch  = 3'd6;
                    i_kon_din = 4'b0010;
                    @(posedge clk);
                    #1;
                end
                chk("gap_hold", {31'd0, o_keyon}, {31'd0, gap_exp});
            end
            i_clk_en      = 1'b1;
            i_zero        = (k == 0);
            i_kon_we      = s_we[k];
            i_kon_ch      = s_ch[k];
            i_kon_din     = s_din[k];
            i_timer_a_ovf = s_ovf[k];
            i_csm_en      = s_csm[k];
            @(posedge clk);
            #1;
            f_ko[k] = o_keyon;
            if (k == 5) f_cm = o_csm_active;
        end
        idle_inputs();
        clear_sched();
    endtask

    initial begin
        idle_inputs();
        clear_sched();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_keyon", {31'd0, o_keyon}, 32'd0);
        chk("rst_state", o_kon_state, 32'd0);
        chk("rst_csm",   {31'd0, o_csm_active}, 32'd0);
        rst = 1'b0;

        // Idle frames
        run_frame(32, ko, cm); chk("idle_f1", ko, 32'h0);
        run_frame(32, ko, cm); chk("idle_f2", ko, 32'h0);
        chk("idle_state", o_kon_state, 32'h0);

        // ch3 all operators, written mid-frame
        sched_wr(10, 3'd3, 4'b1111);
        run_frame(32, ko, cm); chk("ch3_pre", ko, 32'h0);
        chk("ch3_pre_state", o_kon_state, 32'h0);
        run_frame(32, ko, cm); chk("ch3_post", ko, 32'h08080808);
        chk("ch3_state", o_kon_state, 32'h08080808);

        // Last write wins on ch2; ch3 released in the same frame
        sched_wr(5,  3'd2, 4'b0001);
        sched_wr(12, 3'd3, 4'b0000);
        sched_wr(20, 3'd2, 4'b1000);
        run_frame(32, ko, cm); chk("lastwin_pre", ko, 32'h08080808);
        // Write on the commit edge itself
        sched_wr(0, 3'd0, 4'b0001);
        run_frame(32, ko, cm); chk("lastwin_post", ko, 32'h04000000);
        chk("lastwin_state", o_kon_state, 32'h04000000);

        // Commit-edge write appears one frame later; clear and arm CSM
        sched_wr(3, 3'd0, 4'b0000);
        sched_wr(4, 3'd2, 4'b0000);
        sched_ovf(15, 1'b1);
        run_frame(32, ko, cm); chk("edge_wr", ko, 32'h04000001);
        chk("edge_wr_csm", {31'd0, cm}, 32'd0);
        run_frame(32, ko, cm); chk("csm_frame", ko, 32'hFFFFFFFF);
        chk("csm_active", {31'd0, cm}, 32'd1);
        chk("csm_state", o_kon_state, 32'h0);
        // Overflow with CSM disabled is ignored
        sched_ovf(9, 1'b0);
        run_frame(32, ko, cm); chk("csm_after", ko, 32'h0);
        chk("csm_after_act", {31'd0, cm}, 32'd0);
        sched_wr(2, 3'd3, 4'b1111);
        sched_ovf(20, 1'b1);
        run_frame(32, ko, cm); chk("csm_off", ko, 32'h0);
        chk("csm_off_act", {31'd0, cm}, 32'd0);

        // Overflow during a CSM frame queues exactly one more
        sched_ovf(8, 1'b1);
        run_frame(32, ko, cm); chk("csm_q1", ko, 32'hFFFFFFFF);
        chk("csm_q1_act", {31'd0, cm}, 32'd1);
        run_frame(32, ko, cm); chk("csm_q2", ko, 32'hFFFFFFFF);
        chk("csm_q2_act", {31'd0, cm}, 32'd1);
        chk("csm_q2_state", o_kon_state, 32'h08080808);

        // Stall with zero and a write while clk_en is low
        gap_at  = 4;
        gap_exp = 1'b1;
        run_frame(32, ko, cm); chk("csm_revert_gap", ko, 32'h08080808);
        chk("csm_revert_act", {31'd0, cm}, 32'd0);

        // Early zero after 10 ticks; ch6/op2 from the stall write now live
        sched_wr(6, 3'd1, 4'b0100);
        run_frame(10, ko, cm); chk("early_lo", {22'd0, ko[9:0]}, 32'h008);
        chk("early_state", o_kon_state, 32'h08480808);
        for (int c = 0; c < 8; c++) sched_wr(c + 1, 3'(c), 4'b1111);
        run_frame(32, ko, cm); chk("early_post", ko, 32'h08480A08);
        chk("early_post_state", o_kon_state, 32'h08480A08);
        run_frame(32, ko, cm); chk("all_on", ko, 32'hFFFFFFFF);

        // Reset mid-frame with pending write and pending CSM
        sched_wr(4, 3'd5, 4'b1111);
        sched_ovf(6, 1'b1);
        run_frame(12, ko, cm); chk("pre_rst", {20'd0, ko[11:0]}, 32'h00000FFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_keyon", {31'd0, o_keyon}, 32'd0);
        chk("midrst_state", o_kon_state, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("prezero_keyon", {31'd0, o_keyon}, 32'd0);
        run_frame(32, ko, cm); chk("postrst_f1", ko, 32'h0);
        chk("postrst_csm", {31'd0, cm}, 32'd0);
        run_frame(32, ko, cm); chk("postrst_f2", ko, 32'h0);
        chk("postrst_state", o_kon_state, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
